// File: rtl/data_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_ram_arbiter                                              |
// | Purpose  : Arbitrates CPU and debug ports onto a 1R1W data RAM, with     |
// |            independent read/write channels and write-first read bypass.  |
// |            Define DATA_ARB_STARVE_EN to enable debug anti-starvation.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module data_ram_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [9:0]  c_adr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_be,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  // debug / loader port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [9:0]  d_adr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // data RAM
  output logic [9:0]  ram_radr,
  input  logic [31:0] ram_rdata,
  output logic [9:0]  ram_wadr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wen
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_range
    $error("data_ram_arbiter: STARVE_MAX must be within 1..15");
  end

  logic        r_run;
  logic        w_c_rd;
  logic        w_d_rd;
  logic        w_c_wr;
  logic        w_d_wr;
  logic        w_rd_d_prio;
  logic        w_wr_d_prio;
  logic        w_c_rgnt;
  logic        w_d_rgnt;
  logic        w_c_wgnt;
  logic        w_d_wgnt;
  logic        r_c_rvalid;
  logic        r_d_rvalid;
  logic [3:0]  r_byp_be;
  logic [31:0] r_byp_data;
  logic [31:0] w_rdata;

  // Grants stay off until the first edge after reset release, so no read can
  // be launched in the partial cycle in which rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign w_c_rd = r_run & c_req & ~c_we;
  assign w_d_rd = r_run & d_req & ~d_we;
  assign w_c_wr = r_run & c_req &  c_we;
  assign w_d_wr = r_run & d_req &  d_we;

`ifdef DATA_ARB_STARVE_EN
  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] r_rd_starve;
  logic [3:0] r_wr_starve;

  assign w_rd_d_prio = (r_rd_starve == C_STARVE_MAX);
  assign w_wr_d_prio = (r_wr_starve == C_STARVE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_starve <= 4'd0;
      r_wr_starve <= 4'd0;
    end else begin
      if (w_d_rgnt) begin
        r_rd_starve <= 4'd0;
      end else if (w_d_rd && (r_rd_starve < C_STARVE_MAX)) begin
        r_rd_starve <= r_rd_starve + 4'd1;
      end
      if (w_d_wgnt) begin
        r_wr_starve <= 4'd0;
      end else if (w_d_wr && (r_wr_starve < C_STARVE_MAX)) begin
        r_wr_starve <= r_wr_starve + 4'd1;
      end
    end
  end
`else
  assign w_rd_d_prio = 1'b0;
  assign w_wr_d_prio = 1'b0;
`endif

  // Debug wins a channel only when uncontested or when it has starved.
  assign w_d_rgnt = w_d_rd & (~w_c_rd | w_rd_d_prio);
  assign w_c_rgnt = w_c_rd & ~w_d_rgnt;
  assign w_d_wgnt = w_d_wr & (~w_c_wr | w_wr_d_prio);
  assign w_c_wgnt = w_c_wr & ~w_d_wgnt;

  assign c_gnt = w_c_rgnt | w_c_wgnt;
  assign d_gnt = w_d_rgnt | w_d_wgnt;

  always_comb begin
    ram_radr = 10'd0;
    if (w_c_rgnt) begin
      ram_radr = c_adr;
    end else if (w_d_rgnt) begin
      ram_radr = d_adr;
    end
  end

  always_comb begin
    ram_wadr  = 10'd0;
    ram_wdata = 32'd0;
    ram_wen   = 4'b0000;
    if (w_c_wgnt) begin
      ram_wadr  = c_adr;
      ram_wdata = c_wdata;
      ram_wen   = c_be;
    end else if (w_d_wgnt) begin
      ram_wadr  = d_adr;
      ram_wdata = d_wdata;
      ram_wen   = d_be;
    end
  end

  // The RAM returns pre-write data on a same-address collision, so the
  // written bytes are captured here and merged over ram_rdata next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_byp_be   <= 4'b0000;
      r_byp_data <= 32'd0;
    end else begin
      r_c_rvalid <= w_c_rgnt;
      r_d_rvalid <= w_d_rgnt;
      r_byp_data <= ram_wdata;
      if ((w_c_rgnt | w_d_rgnt) && (ram_radr == ram_wadr)) begin
        r_byp_be <= ram_wen;
      end else begin
        r_byp_be <= 4'b0000;
      end
    end
  end

  always_comb begin
    w_rdata = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_byp_be[i]) begin
        w_rdata[8*i +: 8] = r_byp_data[8*i +: 8];
      end
    end
  end

  assign c_rvalid = r_c_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign c_rdata  = w_rdata;
  assign d_rdata  = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_ram_arbiter                                           |
// | Purpose  : Directed self-checking bench for data_ram_arbiter with a      |
// |            read-old 1R1W RAM model.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_data_ram_arbiter;

  localparam int STARVE_MAX = 8;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [9:0]  c_adr;
  logic [31:0] c_wdata, c_rdata;
  logic [3:0]  c_be;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [9:0]  d_adr;
  logic [31:0] d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic [9:0]  ram_radr, ram_wadr;
  logic [31:0] ram_rdata, ram_wdata;
  logic [3:0]  ram_wen;

  int n_vec;
  int n_err;
  int starve_cnt;

  logic [31:0] mem [0:1023];

  data_ram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_adr    (c_adr),
    .c_wdata  (c_wdata),
    .c_be     (c_be),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_adr    (d_adr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_radr (ram_radr),
    .ram_rdata(ram_rdata),
    .ram_wadr (ram_wadr),
    .ram_wdata(ram_wdata),
    .ram_wen  (ram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM returning the old word on a same-address collision.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_radr];
    for (int i = 0; i < 4; i++) begin
      if (ram_wen[i]) mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_c(input logic req, input logic we, input logic [9:0] adr,
                       input logic [31:0] wdata, input logic [3:0] be);
    c_req = req; c_we = we; c_adr = adr; c_wdata = wdata; c_be = be;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [9:0] adr,
                       input logic [31:0] wdata, input logic [3:0] be);
    d_req = req; d_we = we; d_adr = adr; d_wdata = wdata; d_be = be;
  endtask

  task automatic idle();
    set_c(1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    set_d(1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_c(input logic [9:0] adr, input logic [31:0] data);
    idle();
    set_c(1'b1, 1'b1, adr, data, 4'hF);
    #1;
    chk("pre_c_gnt", c_gnt, 1'b1);
    chk("pre_wen", ram_wen, 4'hF);
    cyc();
  endtask

  // Both ports read every cycle; the expected winner comes from a model of
  // the read-channel starvation counter.
  task automatic run_both_read(input int n);
    logic exp_d;
    for (int i = 0; i < n; i++) begin
      set_c(1'b1, 1'b0, 10'h010, 32'd0, 4'd0);
      set_d(1'b1, 1'b0, 10'h030, 32'd0, 4'd0);
      #1;
`ifdef DATA_ARB_STARVE_EN
      exp_d = (starve_cnt == STARVE_MAX);
      if (exp_d) starve_cnt = 0;
      else if (starve_cnt < STARVE_MAX) starve_cnt++;
`else
      exp_d = 1'b0;
`endif
      chk("arb_d_gnt", d_gnt, exp_d);
      chk("arb_c_gnt", c_gnt, !exp_d);
      cyc();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    starve_cnt = 0;
    rst_n = 1'b0;
    set_c(1'b1, 1'b0, 10'h010, 32'd0, 4'd0);
    set_d(1'b1, 1'b1, 10'h070, 32'h12121212, 4'hF);

    // reset state with requests present
    repeat (2) @(negedge clk);
    chk("rst_c_gnt", c_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_wen", ram_wen, 4'b0000);
    chk("rst_c_rvalid", c_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_c_gnt", c_gnt, 1'b0);
    idle();
    cyc();
    chk("rel_c_rvalid", c_rvalid, 1'b0);

    // preload
    write_c(10'h010, 32'h12345678);
    write_c(10'h020, 32'h11111111);
    write_c(10'h040, 32'h00000000);
    idle();
    set_d(1'b1, 1'b1, 10'h030, 32'hCAFEF00D, 4'hF);
    #1;
    chk("dwr_d_gnt", d_gnt, 1'b1);
    chk("dwr_wadr", ram_wadr, 10'h030);
    cyc();

    // CPU read alone
    idle();
    set_c(1'b1, 1'b0, 10'h010, 32'd0, 4'd0);
    #1;
    chk("rd_c_gnt", c_gnt, 1'b1);
    chk("rd_d_gnt", d_gnt, 1'b0);
    chk("rd_radr", ram_radr, 10'h010);
    cyc();
    idle();
    chk("rd_c_rvalid", c_rvalid, 1'b1);
    chk("rd_c_rdata", c_rdata, 32'h12345678);
    chk("rd_d_rvalid", d_rvalid, 1'b0);
    cyc();
    chk("rd_c_rvalid_once", c_rvalid, 1'b0);

    // CPU partial write alongside debug read
    set_c(1'b1, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0011);
    set_d(1'b1, 1'b0, 10'h030, 32'd0, 4'd0);
    #1;
    chk("mix_c_gnt", c_gnt, 1'b1);
    chk("mix_d_gnt", d_gnt, 1'b1);
    chk("mix_wen", ram_wen, 4'b0011);
    chk("mix_wadr", ram_wadr, 10'h020);
    chk("mix_wdata", ram_wdata, 32'hAABBCCDD);
    chk("mix_radr", ram_radr, 10'h030);
    cyc();
    idle();
    chk("mix_d_rvalid", d_rvalid, 1'b1);
    chk("mix_c_rvalid", c_rvalid, 1'b0);
    chk("mix_d_rdata", d_rdata, 32'hCAFEF00D);
    set_c(1'b1, 1'b0, 10'h020, 32'd0, 4'd0);
    cyc();
    idle();
    chk("part_rdata", c_rdata, 32'h1111CCDD);

    // write contention, then debug granted once CPU leaves
    set_c(1'b1, 1'b1, 10'h050, 32'hA5A5A5A5, 4'hF);
    set_d(1'b1, 1'b1, 10'h060, 32'h5A5A5A5A, 4'hF);
    #1;
    chk("wc_c_gnt", c_gnt, 1'b1);
    chk("wc_d_gnt", d_gnt, 1'b0);
    chk("wc_wadr", ram_wadr, 10'h050);
    cyc();
    set_c(1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    #1;
    chk("wc2_d_gnt", d_gnt, 1'b1);
    chk("wc2_wdata", ram_wdata, 32'h5A5A5A5A);
    cyc();

    // empty byte-enable write
    set_d(1'b1, 1'b1, 10'h070, 32'hDEADBEEF, 4'b0000);
    #1;
    chk("be0_d_gnt", d_gnt, 1'b1);
    chk("be0_wen", ram_wen, 4'b0000);
    cyc();

    // same-address read/write: write-first merge
    set_c(1'b1, 1'b0, 10'h040, 32'd0, 4'd0);
    set_d(1'b1, 1'b1, 10'h040, 32'hFFFFFFFF, 4'b0101);
    #1;
    chk("wf_c_gnt", c_gnt, 1'b1);
    chk("wf_d_gnt", d_gnt, 1'b1);
    cyc();
    idle();
    chk("wf_c_rvalid", c_rvalid, 1'b1);
    chk("wf_rdata", c_rdata, 32'h00FF00FF);

    // back-to-back reads without bubble
    set_c(1'b1, 1'b0, 10'h010, 32'd0, 4'd0);
    cyc();
    set_c(1'b1, 1'b0, 10'h040, 32'd0, 4'd0);
    chk("b2b_rdata0", c_rdata, 32'h12345678);
    #1;
    chk("b2b_c_gnt", c_gnt, 1'b1);
    cyc();
    idle();
    chk("b2b_rvalid1", c_rvalid, 1'b1);
    chk("b2b_rdata1", c_rdata, 32'h00FF00FF);

    // sustained read contention
    run_both_read(100);

    // reset dropped while a read is in flight
    set_c(1'b1, 1'b0, 10'h010, 32'd0, 4'd0);
    set_d(1'b1, 1'b1, 10'h070, 32'h34343434, 4'hF);
    #1;
    chk("rr_c_gnt", c_gnt, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rr_c_gnt_off", c_gnt, 1'b0);
    chk("rr_wen", ram_wen, 4'b0000);
    @(negedge clk);
    chk("rr_c_rvalid", c_rvalid, 1'b0);
    chk("rr_d_rvalid", d_rvalid, 1'b0);
    set_c(1'b1, 1'b0, 10'h010, 32'd0, 4'd0);
    set_d(1'b1, 1'b0, 10'h030, 32'd0, 4'd0);
    rst_n = 1'b1;
    #1;
    chk("rr_rel_d_gnt", d_gnt, 1'b0);
    cyc();
    chk("rr_rel_rvalid", c_rvalid, 1'b0);
    starve_cnt = 0;
    run_both_read(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_ram_arbiter.md
DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 8, meaning consecutive denied cycles before the debug port gains priority; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 c_req / c_we / c_adr / c_wdata / c_be  input  1/1/10/32/4  CPU (MA stage) request, write flag, word address, write data, byte enables.
REQ-005 c_gnt  output  1  CPU request accepted this cycle.
REQ-006 c_rvalid  output  1  CPU read data valid; c_rdata  output  32  read data.
REQ-007 d_req / d_we / d_adr / d_wdata / d_be  input  1/1/10/32/4  debug/loader request, same meaning as the CPU port.
REQ-008 d_gnt  output  1 ; d_rvalid  output  1 ; d_rdata  output  32  debug port responses.
REQ-009 ram_radr  output  10 ; ram_rdata  input  32 ; ram_wadr  output  10 ; ram_wdata  output  32 ; ram_wen  output  4  drive the 1R1W data RAM.

Function
REQ-010 The read channel and the write channel SHALL be arbitrated independently each cycle; a read from one port and a write from the other SHALL both be granted in the same cycle.
REQ-011 A read request is req=1, we=0; a write request is req=1, we=1 with be used as given; a write with be=0000 SHALL be granted and SHALL produce ram_wen=0000.
REQ-012 Grants SHALL be combinational from the current requests and the registered starvation state; at most one port SHALL be granted per channel per cycle.
REQ-013 When only one port requests a channel, that port SHALL be granted in the same cycle.
REQ-014 When both request a channel, the CPU SHALL win unless that channel's starvation counter equals STARVE_MAX, in which case the debug port SHALL win.
REQ-015 Each channel SHALL have a 4-bit starvation counter: +1 on each cycle the debug port requests that channel and is denied, saturating at STARVE_MAX; cleared to 0 on the cycle the debug port is granted on that channel.
REQ-016 A requester SHALL hold req, we, adr, wdata, be stable until granted; the arbiter does not queue requests.
REQ-017 ram_radr SHALL equal the granted read address (0 when no read is granted); ram_wadr/ram_wdata SHALL equal the granted writer's values, and ram_wen SHALL equal the granted be, else 0000.
REQ-018 Read latency SHALL be 1 cycle: the x_rvalid of the port granted a read in cycle N SHALL be registered high in cycle N+1 only, with x_rdata = ram_rdata in that cycle.
REQ-019 c_rdata and d_rdata SHALL both be driven from ram_rdata; only rvalid identifies the owner.
REQ-020 A read and a write to the same address in the same cycle SHALL return the newly written bytes in N+1 (write-first), with unwritten bytes holding their old value.
REQ-021 Back-to-back grants on both channels SHALL be sustained every cycle with no bubble.

Reset
REQ-022 While rst_n=0: c_gnt, d_gnt, c_rvalid, d_rvalid SHALL be 0, ram_wen SHALL be 0000, and both starvation counters SHALL be 0.
REQ-023 Reset asserted mid-read SHALL suppress the pending rvalid; no rvalid SHALL appear in the first cycle after release.

Configuration
REQ-024 Macro DATA_ARB_STARVE_EN: when defined, the starvation counters and REQ-014/015 priority override SHALL be present.
REQ-025 When DATA_ARB_STARVE_EN is undefined, the CPU SHALL always win on contention, no counters SHALL exist, and STARVE_MAX SHALL be ignored.

Verification
REQ-026 CPU read adr 0x010 alone, RAM word 0x12345678 -> c_gnt=1 same cycle, c_rvalid=1 and c_rdata=0x12345678 next cycle, d_rvalid=0.
REQ-027 CPU write adr 0x020 data 0xAABBCCDD be=0011 while debug reads adr 0x030 -> both granted same cycle, ram_wen=0011, debug gets rvalid next cycle.
REQ-028 Both ports read continuously with STARVE_MAX=8 and the macro defined -> CPU granted 8 cycles, debug granted on cycle 9, CPU again on cycle 10; the pattern repeats.
REQ-029 Same stimulus with the macro undefined -> d_gnt never asserts over 100 cycles.
REQ-030 Read and write to adr 0x040 same cycle (old 0x00000000, write 0xFFFFFFFF be=0101) -> rdata=0x00FF00FF next cycle.
REQ-031 Drop rst_n the cycle after a read grant -> no rvalid observed, ram_wen=0000, counters=0 after release.
